// File: rtl/retire_trace_checker_if.sv
// rtl/retire_trace_checker_if.sv - golden record stream and retire bus bundle
// Purpose: groups the golden-record valid/ready stream and the per-lane retire
//          bus that feed retire_trace_checker.
// Ports (signals):
//   golden_valid/ready      record handshake (ready driven by the checker)
//   golden_pc/waddr/wdata   reference retire values
//   golden_mask             bit mask applied to wdata compare
//   golden_last             record closes the trace
//   rt_en/pc/waddr/wdata    packed per-lane retire info, lane i in slice i
interface retire_trace_checker_if #(
  parameter int NUM_RETIRE = 2
);
  logic                     golden_valid;
  logic                     golden_ready;
  logic [31:0]              golden_pc;
  logic [4:0]               golden_waddr;
  logic [31:0]              golden_wdata;
  logic [31:0]              golden_mask;
  logic                     golden_last;
  logic [NUM_RETIRE-1:0]    rt_en;
  logic [32*NUM_RETIRE-1:0] rt_pc;
  logic [5*NUM_RETIRE-1:0]  rt_waddr;
  logic [32*NUM_RETIRE-1:0] rt_wdata;

  modport master (
    output golden_valid, golden_pc, golden_waddr, golden_wdata, golden_mask, golden_last,
    output rt_en, rt_pc, rt_waddr, rt_wdata,
    input  golden_ready
  );

  modport slave (
    input  golden_valid, golden_pc, golden_waddr, golden_wdata, golden_mask, golden_last,
    input  rt_en, rt_pc, rt_waddr, rt_wdata,
    output golden_ready
  );
endinterface

// File: rtl/retire_trace_checker.sv
// rtl/retire_trace_checker.sv - multi-lane retire trace checker against a golden FIFO
// Purpose: buffers golden retire records and checks up to NUM_RETIRE retire
//          lanes per cycle against them in program order, latching the first
//          failure with debug context.
// Ports:
//   sys_clk, sys_reset_n    clock, async active-low reset
//   enable                  start checking (sampled in IDLE)
//   bus                     golden stream + retire lanes (slave modport)
//   state                   0 IDLE, 1 RUN, 2 DONE, 3 ERROR
//   err_code                0 none, 1 mismatch, 2 underflow
//   err_lane/pc/waddr/wdata failing lane and its DUT values
//   ref_pc/ref_wdata        golden values of the compared record (0 on underflow)
//   match_cnt               saturating count of matched records
//   fifo_level              golden FIFO occupancy
module retire_trace_checker #(
  parameter int  NUM_RETIRE = 2,
  parameter int  DEPTH      = 16,
  parameter int  CNT_W      = 32,
  localparam int PTR_W      = $clog2(DEPTH),
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                 sys_clk,
  input  logic                 sys_reset_n,
  input  logic                 enable,
  retire_trace_checker_if.slave bus,
  output logic [1:0]           state,
  output logic [1:0]           err_code,
  output logic [1:0]           err_lane,
  output logic [31:0]          err_pc,
  output logic [4:0]           err_waddr,
  output logic [31:0]          err_wdata,
  output logic [31:0]          ref_pc,
  output logic [31:0]          ref_wdata,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [LVL_W-1:0]     fifo_level
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_ERROR = 2'd3} state_e;

  state_e             state_q, state_d;
  logic [1:0]         err_code_q, err_code_d, err_lane_q, err_lane_d;
  logic [31:0]        err_pc_q, err_pc_d, err_wdata_q, err_wdata_d;
  logic [4:0]         err_waddr_q, err_waddr_d;
  logic [31:0]        ref_pc_q, ref_pc_d, ref_wdata_q, ref_wdata_d;
  logic [CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic               last_seen_q, last_seen_d;
  logic               ready_q, ready_d;

  logic [31:0] mem_pc    [DEPTH];
  logic [4:0]  mem_waddr [DEPTH];
  logic [31:0] mem_wdata [DEPTH];
  logic [31:0] mem_mask  [DEPTH];

  logic                  push;
  logic [NUM_RETIRE-1:0] q, has_rec, mism;
  logic [LVL_W-1:0]      off [NUM_RETIRE];
  logic [PTR_W-1:0]      idx [NUM_RETIRE];
  logic [LVL_W-1:0]      cnt, k, pops;
  logic [CNT_W:0]        sum;
  logic                  fail_found;
  logic [1:0]            fail_code, fail_lane;
  logic [31:0]           fail_pc, fail_wdata, fail_ref_pc, fail_ref_wdata;
  logic [4:0]            fail_waddr;

  // Storage is written at the clock edge, so a record pushed this cycle is
  // only visible to the compare logic from the next cycle on.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_pc[wr_ptr_q]    <= bus.golden_pc;
      mem_waddr[wr_ptr_q] <= bus.golden_waddr;
      mem_wdata[wr_ptr_q] <= bus.golden_wdata;
      mem_mask[wr_ptr_q]  <= bus.golden_mask;
    end
  end

  always_comb begin
    push = bus.golden_valid & ready_q;

    // Qualified lanes consume consecutive FIFO entries; unqualified lanes
    // neither compare nor take a slot.
    cnt = '0;
    for (int i = 0; i < NUM_RETIRE; i++) begin
      q[i]       = bus.rt_en[i] & (bus.rt_waddr[5*i +: 5] != 5'd0);
      off[i]     = cnt;
      idx[i]     = rd_ptr_q + off[i][PTR_W-1:0];
      has_rec[i] = off[i] < level_q;
      mism[i]    = q[i] & has_rec[i] &
                   ((bus.rt_pc[32*i +: 32] != mem_pc[idx[i]]) ||
                    (bus.rt_waddr[5*i +: 5] != mem_waddr[idx[i]]) ||
                    ((bus.rt_wdata[32*i +: 32] & mem_mask[idx[i]]) !=
                     (mem_wdata[idx[i]] & mem_mask[idx[i]])));
      if (q[i]) cnt = cnt + LVL_W'(1);
    end
    k = cnt;

    fail_found     = 1'b0;
    fail_code      = 2'd0;
    fail_lane      = 2'd0;
    fail_pc        = '0;
    fail_waddr     = '0;
    fail_wdata     = '0;
    fail_ref_pc    = '0;
    fail_ref_wdata = '0;
    for (int i = 0; i < NUM_RETIRE; i++) begin
      if (!fail_found && mism[i]) begin
        fail_found     = 1'b1;
        fail_code      = 2'd1;
        fail_lane      = 2'(i);
        fail_pc        = bus.rt_pc[32*i +: 32];
        fail_waddr     = bus.rt_waddr[5*i +: 5];
        fail_wdata     = bus.rt_wdata[32*i +: 32];
        fail_ref_pc    = mem_pc[idx[i]];
        fail_ref_wdata = mem_wdata[idx[i]];
      end
    end
    // A qualified lane without a record is an underflow unless the trace has ended.
    if (!fail_found && !last_seen_q) begin
      for (int i = 0; i < NUM_RETIRE; i++) begin
        if (!fail_found && q[i] && !has_rec[i]) begin
          fail_found = 1'b1;
          fail_code  = 2'd2;
          fail_lane  = 2'(i);
          fail_pc    = bus.rt_pc[32*i +: 32];
          fail_waddr = bus.rt_waddr[5*i +: 5];
          fail_wdata = bus.rt_wdata[32*i +: 32];
        end
      end
    end

    state_d     = state_q;
    err_code_d  = err_code_q;
    err_lane_d  = err_lane_q;
    err_pc_d    = err_pc_q;
    err_waddr_d = err_waddr_q;
    err_wdata_d = err_wdata_q;
    ref_pc_d    = ref_pc_q;
    ref_wdata_d = ref_wdata_q;
    match_cnt_d = match_cnt_q;
    last_seen_d = last_seen_q | (push & bus.golden_last);
    pops        = '0;
    sum         = '0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = (last_seen_q && level_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (fail_found) begin
          state_d     = S_ERROR;
          err_code_d  = fail_code;
          err_lane_d  = fail_lane;
          err_pc_d    = fail_pc;
          err_waddr_d = fail_waddr;
          err_wdata_d = fail_wdata;
          ref_pc_d    = fail_ref_pc;
          ref_wdata_d = fail_ref_wdata;
        end else begin
          // Past the end of the trace only the available records are consumed.
          pops        = (k > level_q) ? level_q : k;
          sum         = {1'b0, match_cnt_q} + (CNT_W+1)'(pops);
          match_cnt_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
      end
      default: ;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + pops[PTR_W-1:0];
    level_d  = level_q + LVL_W'(push) - pops;

    if (state_q == S_RUN && !fail_found && last_seen_d && level_d == '0) state_d = S_DONE;

    ready_d = (level_d < LVL_W'(DEPTH)) & ~last_seen_d &
              (state_d != S_ERROR) & (state_d != S_DONE);
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q     <= S_IDLE;
      err_code_q  <= '0;
      err_lane_q  <= '0;
      err_pc_q    <= '0;
      err_waddr_q <= '0;
      err_wdata_q <= '0;
      ref_pc_q    <= '0;
      ref_wdata_q <= '0;
      match_cnt_q <= '0;
      level_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      last_seen_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_code_q  <= err_code_d;
      err_lane_q  <= err_lane_d;
      err_pc_q    <= err_pc_d;
      err_waddr_q <= err_waddr_d;
      err_wdata_q <= err_wdata_d;
      ref_pc_q    <= ref_pc_d;
      ref_wdata_q <= ref_wdata_d;
      match_cnt_q <= match_cnt_d;
      level_q     <= level_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      last_seen_q <= last_seen_d;
      ready_q     <= ready_d;
    end
  end

  assign bus.golden_ready = ready_q;
  assign state      = state_q;
  assign err_code   = err_code_q;
  assign err_lane   = err_lane_q;
  assign err_pc     = err_pc_q;
  assign err_waddr  = err_waddr_q;
  assign err_wdata  = err_wdata_q;
  assign ref_pc     = ref_pc_q;
  assign ref_wdata  = ref_wdata_q;
  assign match_cnt  = match_cnt_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_retire_trace_checker.sv
// tb/tb_retire_trace_checker.sv - self-checking bench for retire_trace_checker
module tb_retire_trace_checker;
  localparam int NR    = 2;
  localparam int DEPTH = 16;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2, ST_ERR = 2'd3;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n;
  logic        enable;
  logic [1:0]  state, err_code, err_lane;
  logic [31:0] err_pc, err_wdata, ref_pc, ref_wdata, match_cnt;
  logic [4:0]  err_waddr, fifo_level;

  retire_trace_checker_if #(.NUM_RETIRE(NR)) bus ();

  retire_trace_checker #(.NUM_RETIRE(NR), .DEPTH(DEPTH), .CNT_W(32)) dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .enable      (enable),
    .bus         (bus),
    .state       (state),
    .err_code    (err_code),
    .err_lane    (err_lane),
    .err_pc      (err_pc),
    .err_waddr   (err_waddr),
    .err_wdata   (err_wdata),
    .ref_pc      (ref_pc),
    .ref_wdata   (ref_wdata),
    .match_cnt   (match_cnt),
    .fifo_level  (fifo_level)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  code;
    logic [1:0]  lane;
    logic [31:0] epc;
    logic [4:0]  ewaddr;
    logic [31:0] ewdata;
    logic [31:0] rpc;
    logic [31:0] rwdata;
    logic [31:0] mcnt;
    logic [4:0]  lvl;
    logic        rdy;
  } exp_t;

  typedef struct {
    bit         gv;
    int         gidx;
    bit         glast;
    bit         en;
    bit [1:0]   rten;
    int         l0;
    int         l1;
    logic [1:0] st;
    int         mcnt;
    int         lvl;
    bit         rdy;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[7];
  int   n_cmp  = 0;
  int   n_miss = 0;

  function automatic logic [31:0] rec_pc(int i);
    return 32'h0000_1000 + 32'(i) * 32'd4;
  endfunction
  function automatic logic [4:0] rec_waddr(int i);
    return 5'((i % 31) + 1);
  endfunction
  function automatic logic [31:0] rec_wdata(int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic exp_t ok(logic [1:0] st, int mcnt, int lvl, bit rdy);
    exp_t e;
    e.st = st; e.code = 2'd0; e.lane = 2'd0; e.epc = '0; e.ewaddr = '0; e.ewdata = '0;
    e.rpc = '0; e.rwdata = '0; e.mcnt = 32'(mcnt); e.lvl = 5'(lvl); e.rdy = rdy;
    return e;
  endfunction

  function automatic exp_t err(logic [1:0] code, logic [1:0] lane, logic [31:0] epc,
                               logic [4:0] ewa, logic [31:0] ewd, logic [31:0] rpc,
                               logic [31:0] rwd, int mcnt, int lvl);
    exp_t e;
    e.st = ST_ERR; e.code = code; e.lane = lane; e.epc = epc; e.ewaddr = ewa; e.ewdata = ewd;
    e.rpc = rpc; e.rwdata = rwd; e.mcnt = 32'(mcnt); e.lvl = 5'(lvl); e.rdy = 1'b0;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_exp(exp_t e);
    chk("state",        32'(state),            32'(e.st));
    chk("err_code",     32'(err_code),         32'(e.code));
    chk("err_lane",     32'(err_lane),         32'(e.lane));
    chk("err_pc",       err_pc,                e.epc);
    chk("err_waddr",    32'(err_waddr),        32'(e.ewaddr));
    chk("err_wdata",    err_wdata,             e.ewdata);
    chk("ref_pc",       ref_pc,                e.rpc);
    chk("ref_wdata",    ref_wdata,             e.rwdata);
    chk("match_cnt",    match_cnt,             e.mcnt);
    chk("fifo_level",   32'(fifo_level),       32'(e.lvl));
    chk("golden_ready", 32'(bus.golden_ready), 32'(e.rdy));
  endtask

  task automatic idle_inputs();
    enable           = 1'b0;
    bus.golden_valid = 1'b0;
    bus.golden_pc    = '0;
    bus.golden_waddr = '0;
    bus.golden_wdata = '0;
    bus.golden_mask  = '0;
    bus.golden_last  = 1'b0;
    bus.rt_en        = '0;
    bus.rt_pc        = '0;
    bus.rt_waddr     = '0;
    bus.rt_wdata     = '0;
  endtask

  task automatic push_raw(logic [31:0] pc, logic [4:0] wa, logic [31:0] wd,
                          logic [31:0] mask, logic last);
    bus.golden_valid = 1'b1;
    bus.golden_pc    = pc;
    bus.golden_waddr = wa;
    bus.golden_wdata = wd;
    bus.golden_mask  = mask;
    bus.golden_last  = last;
  endtask

  task automatic push_rec(int i, logic last);
    push_raw(rec_pc(i), rec_waddr(i), rec_wdata(i), 32'hFFFF_FFFF, last);
  endtask

  task automatic lane(int l, logic [31:0] pc, logic [4:0] wa, logic [31:0] wd);
    bus.rt_en[l]           = 1'b1;
    bus.rt_pc[32*l +: 32]  = pc;
    bus.rt_waddr[5*l +: 5] = wa;
    bus.rt_wdata[32*l +: 32] = wd;
  endtask

  task automatic lane_rec(int l, int i);
    lane(l, rec_pc(i), rec_waddr(i), rec_wdata(i));
  endtask

  // One clock: outputs registered at this edge are compared against the
  // oldest scoreboard entry, then the inputs return to idle.
  task automatic cycle();
    exp_t e;
    @(posedge sys_clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_miss++;
      $display("FAIL scoreboard: no expectation queued at t=%0t", $time);
    end else begin
      e = sb_q.pop_front();
      check_exp(e);
    end
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    sys_reset_n = 1'b0;
    #3;
    check_exp(ok(ST_IDLE, 0, 0, 1'b0));
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    sb_q.push_back(ok(ST_IDLE, 0, 0, 1'b1));
    cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sys_reset_n = 1'b0;
    idle_inputs();

    // gv gidx glast en rten l0 l1 state mcnt lvl rdy
    tbl[0] = '{1, 0, 0, 0, 2'b00, 0, 0, ST_IDLE, 0, 1, 1};
    tbl[1] = '{1, 1, 0, 0, 2'b11, 5, 6, ST_IDLE, 0, 2, 1};
    tbl[2] = '{1, 2, 0, 0, 2'b00, 0, 0, ST_IDLE, 0, 3, 1};
    tbl[3] = '{1, 3, 0, 1, 2'b00, 0, 0, ST_RUN,  0, 4, 1};
    tbl[4] = '{0, 0, 0, 0, 2'b11, 0, 1, ST_RUN,  2, 2, 1};
    tbl[5] = '{0, 0, 0, 0, 2'b11, 2, 3, ST_RUN,  4, 0, 1};
    tbl[6] = '{0, 0, 0, 0, 2'b00, 0, 0, ST_RUN,  4, 0, 1};

    // Basic flow: fill in IDLE (retires ignored), then two lanes per cycle.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      if (tbl[v].gv) push_rec(tbl[v].gidx, tbl[v].glast);
      enable = tbl[v].en;
      if (tbl[v].rten[0]) lane_rec(0, tbl[v].l0);
      if (tbl[v].rten[1]) lane_rec(1, tbl[v].l1);
      sb_q.push_back(ok(tbl[v].st, tbl[v].mcnt, tbl[v].lvl, tbl[v].rdy));
      cycle();
    end

    // Masked wdata compare, then a masked-bit mismatch.
    do_reset();
    push_raw(32'h2000, 5'd7, 32'h1234_5678, 32'hFFFF_0000, 1'b0);
    enable = 1'b1;
    sb_q.push_back(ok(ST_RUN, 0, 1, 1'b1)); cycle();
    push_raw(32'h2000, 5'd7, 32'h1234_5678, 32'hFFFF_0000, 1'b0);
    sb_q.push_back(ok(ST_RUN, 0, 2, 1'b1)); cycle();
    lane(0, 32'h2000, 5'd7, 32'h1234_0000);
    sb_q.push_back(ok(ST_RUN, 1, 1, 1'b1)); cycle();
    lane(0, 32'h2000, 5'd7, 32'h1235_0000);
    sb_q.push_back(err(2'd1, 2'd0, 32'h2000, 5'd7, 32'h1235_0000, 32'h2000, 32'h1234_5678, 1, 1));
    cycle();

    // Lane 1 PC off by 4; ERROR then stays frozen.
    do_reset();
    push_rec(0, 1'b0);
    sb_q.push_back(ok(ST_IDLE, 0, 1, 1'b1)); cycle();
    push_rec(1, 1'b0); enable = 1'b1;
    sb_q.push_back(ok(ST_RUN, 0, 2, 1'b1)); cycle();
    lane_rec(0, 0); lane(1, rec_pc(1) + 32'd4, rec_waddr(1), rec_wdata(1));
    sb_q.push_back(err(2'd1, 2'd1, rec_pc(1) + 32'd4, rec_waddr(1), rec_wdata(1),
                       rec_pc(1), rec_wdata(1), 0, 2));
    cycle();
    push_rec(2, 1'b0); lane_rec(0, 0); lane_rec(1, 1);
    sb_q.push_back(err(2'd1, 2'd1, rec_pc(1) + 32'd4, rec_waddr(1), rec_wdata(1),
                       rec_pc(1), rec_wdata(1), 0, 2));
    cycle();

    // Underflow on lane 1 with lane 0 matching.
    do_reset();
    push_rec(0, 1'b0); enable = 1'b1;
    sb_q.push_back(ok(ST_RUN, 0, 1, 1'b1)); cycle();
    lane_rec(0, 0); lane_rec(1, 1);
    sb_q.push_back(err(2'd2, 2'd1, rec_pc(1), rec_waddr(1), rec_wdata(1), 32'h0, 32'h0, 0, 1));
    cycle();

    // Trace end: 3 records, last flagged, 4 retires offered.
    do_reset();
    push_rec(0, 1'b0);
    sb_q.push_back(ok(ST_IDLE, 0, 1, 1'b1)); cycle();
    push_rec(1, 1'b0);
    sb_q.push_back(ok(ST_IDLE, 0, 2, 1'b1)); cycle();
    push_rec(2, 1'b1);
    sb_q.push_back(ok(ST_IDLE, 0, 3, 1'b0)); cycle();
    enable = 1'b1;
    sb_q.push_back(ok(ST_RUN, 0, 3, 1'b0)); cycle();
    lane_rec(0, 0); lane_rec(1, 1);
    sb_q.push_back(ok(ST_RUN, 2, 1, 1'b0)); cycle();
    lane_rec(0, 2); lane_rec(1, 9);
    sb_q.push_back(ok(ST_DONE, 3, 0, 1'b0)); cycle();
    push_rec(3, 1'b0); lane_rec(0, 3); enable = 1'b1;
    sb_q.push_back(ok(ST_DONE, 3, 0, 1'b0)); cycle();

    // Full FIFO, blocked push, waddr=0 skip lane, pointer wrap.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      push_rec(i, 1'b0);
      sb_q.push_back(ok(ST_IDLE, 0, i + 1, i < DEPTH - 1)); cycle();
    end
    enable = 1'b1;
    sb_q.push_back(ok(ST_RUN, 0, 16, 1'b0)); cycle();
    push_rec(16, 1'b0); lane_rec(0, 0); lane_rec(1, 1);
    sb_q.push_back(ok(ST_RUN, 2, 14, 1'b1)); cycle();
    push_rec(16, 1'b0);
    sb_q.push_back(ok(ST_RUN, 2, 15, 1'b1)); cycle();
    lane(0, 32'hDEAD_0000, 5'd0, 32'h0); lane_rec(1, 2);
    sb_q.push_back(ok(ST_RUN, 3, 14, 1'b1)); cycle();
    lane_rec(0, 3);
    sb_q.push_back(ok(ST_RUN, 4, 13, 1'b1)); cycle();
    for (int j = 4; j < 16; j += 2) begin
      lane_rec(0, j); lane_rec(1, j + 1);
      sb_q.push_back(ok(ST_RUN, j + 2, 15 - j, 1'b1)); cycle();
    end
    lane_rec(0, 16);
    sb_q.push_back(ok(ST_RUN, 17, 0, 1'b1)); cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
    $finish;
  end
endmodule
